// File: rtl/tri_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tri_seq_ctrl
//
// Command-driven triangle-wave sequencer. A burst command (peak, hold, reps)
// is accepted over a valid/ready handshake into a one-deep pending buffer.
// The sequencer then plays reps periods of rise / hold-high / fall / hold-low
// on d_out, and can chain straight into the next pending command with no
// idle cycle in between.
//
// Parameters
//   DW  width of d_out and cmd_peak
//   HW  width of cmd_hold and the plateau counter
//   RW  width of cmd_reps and the repetition counter
//
// Ports
//   clk        system clock, rising edge
//   res        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  command can be taken (no command pending and no abort)
//   cmd_peak   top value of the triangle
//   cmd_hold   plateau length minus one
//   cmd_reps   number of triangle periods
//   abort      synchronous stop request, level-sampled, highest priority
//   d_out      registered waveform sample
//   busy       sequencer is not idle
//   phase      state code: IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4
//   done       one-cycle pulse after the final repetition completes
//   err        one-cycle pulse when an illegal command is discarded
//   aborted    one-cycle pulse when abort cancels activity
// ---------------------------------------------------------------------------
module tri_seq_ctrl #(
   parameter int DW = 10,
   parameter int HW = 8,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          res,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [DW-1:0] cmd_peak,
   input  logic [HW-1:0] cmd_hold,
   input  logic [RW-1:0] cmd_reps,
   input  logic          abort,
   output logic [DW-1:0] d_out,
   output logic          busy,
   output logic [2:0]    phase,
   output logic          done,
   output logic          err,
   output logic          aborted
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RISE    = 3'd1,
      HOLD_HI = 3'd2,
      FALL    = 3'd3,
      HOLD_LO = 3'd4
   } state_t;

   state_t        state, state_nxt;

   logic [DW-1:0] dout_nxt;
   logic [HW-1:0] con, con_nxt;
   logic [RW-1:0] rep_cnt, rep_nxt;
   logic          done_nxt, err_nxt, aborted_nxt;

   logic          pend_valid;
   logic [DW-1:0] pend_peak;
   logic [HW-1:0] pend_hold;
   logic [RW-1:0] pend_reps;

   logic [DW-1:0] act_peak;
   logic [HW-1:0] act_hold;
   logic [RW-1:0] act_reps;

   logic          accept;
   logic          load;
   logic          pend_clr;
   logic          pend_legal;
   logic [RW-1:0] reps_m1;

   // A command with a zero peak or zero repetitions would produce no
   // waveform at all, so it is rejected instead of being played.
   function automatic logic cmd_legal(input logic [DW-1:0] peak,
                                      input logic [RW-1:0] reps);
      return (peak != '0) && (reps != '0);
   endfunction

   assign cmd_ready  = !pend_valid && !abort;
   assign accept     = cmd_valid && cmd_ready;
   assign pend_legal = cmd_legal(pend_peak, pend_reps);
   // act_reps is never zero while a burst runs, so this cannot underflow.
   assign reps_m1    = act_reps - RW'(1);

   assign busy  = (state != IDLE);
   assign phase = state;

   // Next-state and next-output decode
   always_comb begin
      state_nxt   = state;
      dout_nxt    = d_out;
      con_nxt     = con;
      rep_nxt     = rep_cnt;
      pend_clr    = 1'b0;
      load        = 1'b0;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      aborted_nxt = 1'b0;

      if (abort) begin
         state_nxt   = IDLE;
         dout_nxt    = '0;
         con_nxt     = '0;
         rep_nxt     = '0;
         pend_clr    = 1'b1;
         aborted_nxt = (state != IDLE) || pend_valid;
      end else begin
         case (state)
            IDLE: begin
               if (pend_valid) begin
                  pend_clr = 1'b1;
                  if (pend_legal) begin
                     load      = 1'b1;
                     state_nxt = RISE;
                     dout_nxt  = '0;
                     con_nxt   = '0;
                     rep_nxt   = '0;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end

            RISE: begin
               dout_nxt = d_out + DW'(1);
               // Leave one step early so d_out lands exactly on the peak.
               if (d_out == act_peak - DW'(1)) begin
                  state_nxt = HOLD_HI;
               end
            end

            HOLD_HI: begin
               if (con == act_hold) begin
                  con_nxt   = '0;
                  state_nxt = FALL;
               end else begin
                  con_nxt = con + HW'(1);
               end
            end

            FALL: begin
               dout_nxt = d_out - DW'(1);
               if (d_out == DW'(1)) begin
                  state_nxt = HOLD_LO;
               end
            end

            HOLD_LO: begin
               if (con == act_hold) begin
                  con_nxt = '0;
                  if (rep_cnt != reps_m1) begin
                     rep_nxt   = rep_cnt + RW'(1);
                     state_nxt = RISE;
                  end else begin
                     done_nxt = 1'b1;
                     rep_nxt  = '0;
                     // Chain into a waiting command without an idle cycle.
                     if (pend_valid) begin
                        pend_clr = 1'b1;
                        if (pend_legal) begin
                           load      = 1'b1;
                           state_nxt = RISE;
                           dout_nxt  = '0;
                        end else begin
                           err_nxt   = 1'b1;
                           state_nxt = IDLE;
                        end
                     end else begin
                        state_nxt = IDLE;
                     end
                  end
               end else begin
                  con_nxt = con + HW'(1);
               end
            end

            default: begin
               state_nxt = IDLE;
               dout_nxt  = '0;
               con_nxt   = '0;
               rep_nxt   = '0;
            end
         endcase
      end
   end

   // Control and output registers
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state      <= IDLE;
         d_out      <= '0;
         con        <= '0;
         rep_cnt    <= '0;
         pend_valid <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         state   <= state_nxt;
         d_out   <= dout_nxt;
         con     <= con_nxt;
         rep_cnt <= rep_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         aborted <= aborted_nxt;
         // Accept and clear never coincide: accept needs an empty buffer,
         // clear needs a full one (or abort, which blocks accept).
         if (pend_clr) begin
            pend_valid <= 1'b0;
         end else if (accept) begin
            pend_valid <= 1'b1;
         end
      end
   end

   // Command payload registers; only meaningful while their valid/busy
   // qualifier is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         pend_peak <= cmd_peak;
         pend_hold <= cmd_hold;
         pend_reps <= cmd_reps;
      end
      if (load) begin
         act_peak <= pend_peak;
         act_hold <= pend_hold;
         act_reps <= pend_reps;
      end
   end

endmodule

// File: tb/tb_tri_seq_ctrl.sv
module tb_tri_seq_ctrl;

   logic       clk;
   logic       res;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_peak;
   logic [7:0] cmd_hold;
   logic [3:0] cmd_reps;
   logic       abort;
   logic [9:0] d_out;
   logic       busy;
   logic [2:0] phase;
   logic       done;
   logic       err;
   logic       aborted;

   int n_vec;
   int n_bad;

   tri_seq_ctrl #(.DW(10), .HW(8), .RW(4)) dut (
      .clk       (clk),
      .res       (res),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_peak  (cmd_peak),
      .cmd_hold  (cmd_hold),
      .cmd_reps  (cmd_reps),
      .abort     (abort),
      .d_out     (d_out),
      .busy      (busy),
      .phase     (phase),
      .done      (done),
      .err       (err),
      .aborted   (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [9:0] pk;
      logic [7:0] hd;
      logic [3:0] rp;
      logic       ab;
      logic [9:0] e_d;
      logic       e_busy;
      logic [2:0] e_ph;
      logic       e_done;
      logic       e_err;
      logic       e_abd;
      logic       e_rdy;
   } vec_t;

   vec_t vq[$];

   function automatic void add_cmd(input logic [9:0] pk, input logic [7:0] hd,
                                   input logic [3:0] rp, input logic [9:0] d,
                                   input logic b, input logic [2:0] ph,
                                   input logic dn, input logic er,
                                   input logic abd, input logic rdy);
      vec_t t;
      t.v = 1'b1; t.pk = pk; t.hd = hd; t.rp = rp; t.ab = 1'b0;
      t.e_d = d; t.e_busy = b; t.e_ph = ph; t.e_done = dn;
      t.e_err = er; t.e_abd = abd; t.e_rdy = rdy;
      vq.push_back(t);
   endfunction

   function automatic void add_nop(input logic [9:0] d, input logic b,
                                   input logic [2:0] ph, input logic dn,
                                   input logic er, input logic abd,
                                   input logic rdy);
      vec_t t;
      t.v = 1'b0; t.pk = '0; t.hd = '0; t.rp = '0; t.ab = 1'b0;
      t.e_d = d; t.e_busy = b; t.e_ph = ph; t.e_done = dn;
      t.e_err = er; t.e_abd = abd; t.e_rdy = rdy;
      vq.push_back(t);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic [9:0] d, input logic b,
                           input logic [2:0] ph, input logic dn, input logic er,
                           input logic abd, input logic rdy);
      n_vec++;
      if ({d_out, busy, phase, done, err, aborted, cmd_ready} !==
          {d, b, ph, dn, er, abd, rdy}) begin
         n_bad++;
         $display("FAIL %s: got d=%0d busy=%0b ph=%0d done=%0b err=%0b abt=%0b rdy=%0b, expected d=%0d busy=%0b ph=%0d done=%0b err=%0b abt=%0b rdy=%0b",
                  nm, d_out, busy, phase, done, err, aborted, cmd_ready,
                  d, b, ph, dn, er, abd, rdy);
      end
   endtask

   // Drive inputs on the falling edge, sample just after the rising edge.
   task automatic step(input logic v, input logic [9:0] pk, input logic [7:0] hd,
                       input logic [3:0] rp, input logic ab);
      @(negedge clk);
      cmd_valid = v;
      cmd_peak  = pk;
      cmd_hold  = hd;
      cmd_reps  = rp;
      abort     = ab;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].v, vq[i].pk, vq[i].hd, vq[i].rp, vq[i].ab);
         chk_outs($sformatf("%s[%0d]", tag, i), vq[i].e_d, vq[i].e_busy,
                  vq[i].e_ph, vq[i].e_done, vq[i].e_err, vq[i].e_abd,
                  vq[i].e_rdy);
      end
      vq.delete();
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      int max_d;
      bit found;

      n_vec     = 0;
      n_bad     = 0;
      res       = 1'b1;
      cmd_valid = 1'b0;
      cmd_peak  = '0;
      cmd_hold  = '0;
      cmd_reps  = '0;
      abort     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset_state", 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      res = 1'b0;
      #1;
      chk("ready_after_reset", int'(cmd_ready), 1);

      // Single burst: peak 4, hold 2, reps 1
      add_cmd(10'd4, 8'd2, 4'd1, 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         add_nop(10'd4, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd4, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd3, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         add_nop(10'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_vecs("single");

      // Back-to-back: A (3,0,1) running, B (2,1,1) pending
      add_cmd(10'd3, 8'd0, 4'd1, 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_cmd(10'd2, 8'd1, 4'd1, 10'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd3, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      add_nop(10'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd2, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd2, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_vecs("b2b");

      // Illegal commands: peak 0, then reps 0
      add_cmd(10'd0, 8'd3, 4'd2, 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add_cmd(10'd5, 8'd0, 4'd0, 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_nop(10'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add_nop(10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_vecs("illegal");

      // Long burst: peak 300, hold 200, reps 2 -> 2*(600+402) busy cycles
      step(1'b1, 10'd300, 8'd200, 4'd2, 1'b0);
      busy_cnt = 0;
      done_cnt = 0;
      max_d    = 0;
      for (int i = 0; i < 2100; i++) begin
         step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (int'(d_out) > max_d) max_d = int'(d_out);
      end
      chk("long_busy_cycles", busy_cnt, 2004);
      chk("long_max_dout", max_d, 300);
      chk("long_done_pulses", done_cnt, 1);

      // Abort during FALL at d_out=150 with a command pending
      step(1'b1, 10'd200, 8'd0, 4'd1, 1'b0);
      step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
      step(1'b1, 10'd5, 8'd0, 4'd1, 1'b0);
      chk("abort_pending_ready", int'(cmd_ready), 0);
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
         if (phase == 3'd3 && d_out == 10'd150) found = 1'b1;
      end
      chk("abort_reach_fall150", int'(found), 1);
      step(1'b0, 10'd0, 8'd0, 4'd0, 1'b1);
      chk_outs("abort_edge", 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
      chk_outs("abort_after", 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      chk("abort_no_restart", busy_cnt, 0);
      chk("abort_no_done", done_cnt, 0);

      // Asynchronous reset during HOLD_HI with a command pending
      step(1'b1, 10'd3, 8'd5, 4'd2, 1'b0);
      step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
      step(1'b1, 10'd7, 8'd0, 4'd1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
         if (phase == 3'd2) found = 1'b1;
      end
      chk("rst_reach_hold_hi", int'(found), 1);
      #2;
      res = 1'b1;
      #1;
      chk_outs("rst_async", 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_outs($sformatf("rst_held[%0d]", i), 10'd0, 1'b0, 3'd0,
                  1'b0, 1'b0, 1'b0, 1'b1);
      end
      @(negedge clk);
      res = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 10'd0, 8'd0, 4'd0, 1'b0);
         if (busy) busy_cnt++;
      end
      chk("rst_pending_lost", busy_cnt, 0);

      // After reset: peak 1, hold 0, reps 3 -> 0,1,1,0 x3
      add_cmd(10'd1, 8'd0, 4'd3, 10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
         add_nop(10'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
         add_nop(10'd1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
         add_nop(10'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
         add_nop(10'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      add_nop(10'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      add_nop(10'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_vecs("peak1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tri_seq_ctrl.md
# tri_seq_ctrl

Command-driven sequencer for the triangle-wave datapath. It accepts burst commands over a valid/ready handshake and buffers one pending command. It then drives a programmable triangle (rise, hold-high, fall, hold-low) for a commanded number of repetitions, and reports busy, done, error and abort status. The block sits between the system control path and the DAC output word, replacing the fixed-constant triangle generator wherever peak and hold must be set at run time.

## Interface
- DW, 10, width of d_out and cmd_peak
- HW, 8, width of cmd_hold and the hold counter
- RW, 4, width of cmd_reps and the repetition counter
- clk  input  1  system clock, all state changes on rising edge
- res  input  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can take a command; equals !pend_valid && !abort
- cmd_peak  input  DW  top value of the triangle
- cmd_hold  input  HW  plateau length; the plateau lasts cmd_hold+1 cycles
- cmd_reps  input  RW  number of triangle periods
- abort  input  1  synchronous stop request, level-sampled
- d_out  output  DW  waveform sample, registered
- busy  output  1  state != IDLE
- phase  output  3  state code: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4
- done  output  1  one-cycle pulse when the final repetition completes
- err  output  1  one-cycle pulse when an illegal command is discarded
- aborted  output  1  one-cycle pulse when abort terminates activity

## Operation
- Buffering:
  - An accept (cmd_valid && cmd_ready at an edge) writes the pending register (peak, hold, reps) and sets pend_valid.
  - A load copies pending to the active registers and clears pend_valid.
- IDLE with pend_valid:
  - If pend peak==0 or pend reps==0: discard the command, pulse err, stay IDLE.
  - Otherwise: load, rep_cnt<=0, con<=0, d_out<=0, go to RISE.
- RISE: d_out<=d_out+1 each cycle. Entering HOLD_HI happens at the edge where d_out==peak-1, so d_out lands on exactly peak.
- HOLD_HI: con<=con+1 each cycle. At the edge where con==hold: con<=0, go to FALL.
- FALL: d_out<=d_out-1 each cycle. At the edge where d_out==1: d_out<=0, go to HOLD_LO.
- HOLD_LO: counts the same way as HOLD_HI. At the edge where con==hold:
  - If rep_cnt != reps-1: rep_cnt<=rep_cnt+1, go to RISE.
  - Else pulse done. Then, if pend_valid holds a legal command, load it and go directly to RISE with no gap. If it holds an illegal command, discard it, pulse err, go to IDLE. Otherwise go to IDLE.
- abort has highest priority in every state:
  - d_out<=0, con<=0, rep_cnt<=0, pend_valid<=0, state<=IDLE.
  - aborted pulses if busy or pend_valid was 1; done is not pulsed.
  - cmd_ready is 0 while abort is high, so no command is accepted in the abort cycle.
- Arithmetic: all counters are unsigned. d_out never wraps: it stays within 0..peak by construction. Peak = 2^DW-1 is legal.
- New commands may be accepted while busy; only one command can be pending.

## Timing
- Reset values: d_out=0, state=IDLE, phase=0, busy=0, done=0, err=0, aborted=0, pend_valid=0, con=0, rep_cnt=0. After reset deasserts, cmd_ready=1.
- Reset asserted mid-burst returns to the reset values immediately (asynchronous). The pending command is lost.
- Accept at edge N → load and RISE at edge N+1 → d_out=1 at edge N+2 → d_out=P at edge N+1+P.
- One period = 2P + 2(H+1) cycles: P rising, H+1 at peak, P falling, H+1 at zero.
- Burst of R reps = R × period cycles. The done pulse occurs in the cycle after the final HOLD_LO exit edge.
- Back-to-back: the first RISE increment of the next command follows the last HOLD_LO cycle of the previous one, with zero idle cycles.
- cmd_ready drops in the cycle after an accept. It rises in the cycle after a load or abort.

## Test plan
- Reset, then command peak=4, hold=2, reps=1 → d_out sequence 0,1,2,3,4,4,4,4,3,2,1,0,0,0,0. Exactly 14 cycles busy, 1 done pulse, then phase=0.
- Peak=300, hold=200, reps=2 → 2×(600+402)=2004 busy cycles, max d_out=300, single done pulse at the end.
- Command A (peak=3, hold=0, reps=1) accepted, then B (peak=2, hold=1, reps=1) accepted while A runs → B rises immediately after A's HOLD_LO with no IDLE cycle. Two done pulses. cmd_ready stays 0 while B is pending.
- Command with peak=0, and separately reps=0 → err pulses once for each, busy stays 0, d_out stays 0.
- Abort asserted for 1 cycle while in FALL with d_out=150 and a command pending → d_out=0 and IDLE on the next edge, aborted pulse, no done pulse, pending dropped (no new burst starts).
- res asserted for 3 cycles during HOLD_HI → all outputs read reset values asynchronously. After release, a new command peak=1, hold=0, reps=3 gives 0,1,1,0,… with a period of 4 cycles and 12 busy cycles.
